// File: rtl/sdram_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter in front of the SDRAM controller host interface.
// Latency: request at IDLE edge T -> m_* valid at T+1; controller compl at C -> port compl at C+1.
// Backpressure: one transaction in flight; requesters hold their request until their compl pulse.
module sdram_arbiter #(
    parameter int FIXED_PRIO    = 0,
    parameter int RESET_HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic        p0_wr_en,
    input  logic [1:0]  p0_bytesel,
    output logic [15:0] p0_rdata,
    output logic        p0_compl,
    input  logic [31:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic        p1_wr_en,
    input  logic [1:0]  p1_bytesel,
    output logic [15:0] p1_rdata,
    output logic        p1_compl,
    output logic [31:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_wr_en,
    output logic [1:0]  m_bytesel,
    input  logic [15:0] m_rdata,
    input  logic        m_compl,
    input  logic        m_config_done,
    output logic        grant
);

    // Counter must reach RESET_HOLDOFF-1; keep at least one bit for degenerate settings.
    localparam int CNT_W = (RESET_HOLDOFF < 2) ? 1 : $clog2(RESET_HOLDOFF + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((RESET_HOLDOFF > 0) ? RESET_HOLDOFF - 1 : 0);

    typedef enum logic [2:0] {
        ST_HOLDOFF  = 3'd0,
        ST_WAIT_CFG = 3'd1,
        ST_IDLE     = 3'd2,
        ST_BUSY     = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rr_q, rr_d;          // port favoured when both request
    logic [31:0]        m_addr_q, m_addr_d;
    logic [15:0]        m_wdata_q, m_wdata_d;
    logic               m_wr_en_q, m_wr_en_d;
    logic [1:0]         m_bytesel_q, m_bytesel_d;
    logic [15:0]        p0_rdata_q, p0_rdata_d;
    logic [15:0]        p1_rdata_q, p1_rdata_d;
    logic               p0_compl_q, p0_compl_d;
    logic               p1_compl_q, p1_compl_d;
    logic               grant_q, grant_d;

    logic req0, req1, any_req, win;
    logic grant_start, txn_done;

    assign req0    = |p0_bytesel;
    assign req1    = |p1_bytesel;
    assign any_req = req0 | req1;

    // Winner selection: lone requester wins; on a tie use the favoured port or port 0 when fixed.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        end else begin
            win = req1;
        end
    end

    assign grant_start = (state_q == ST_IDLE) && any_req;
    assign txn_done    = (state_q == ST_BUSY) && m_compl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLDOFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; controller completions outside BUSY are deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLDOFF:  if (cnt_q == HOLD_LAST) state_d = ST_WAIT_CFG;
            ST_WAIT_CFG: if (m_config_done)      state_d = ST_IDLE;
            ST_IDLE:     if (any_req)            state_d = ST_BUSY;
            ST_BUSY:     if (m_compl)            state_d = ST_RELEASE;
            ST_RELEASE:                          state_d = ST_IDLE;
            default:                             state_d = ST_HOLDOFF;
        endcase
    end

    // Output/datapath logic: latch the winner on grant, route completion back on done.
    always_comb begin
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wr_en_d   = m_wr_en_q;
        m_bytesel_d = m_bytesel_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_compl_d  = 1'b0;
        p1_compl_d  = 1'b0;
        grant_d     = grant_q;

        if ((state_q == ST_HOLDOFF) && (cnt_q != HOLD_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (grant_start) begin
            grant_d = win;
            rr_d    = ~win;
            if (win) begin
                m_addr_d    = p1_addr;
                m_wdata_d   = p1_wdata;
                m_wr_en_d   = p1_wr_en;
                m_bytesel_d = p1_bytesel;
            end else begin
                m_addr_d    = p0_addr;
                m_wdata_d   = p0_wdata;
                m_wr_en_d   = p0_wr_en;
                m_bytesel_d = p0_bytesel;
            end
        end

        if (txn_done) begin
            // Drop bytesel together with the port compl so the controller never relaunches.
            m_bytesel_d = 2'b00;
            if (grant_q) begin
                p1_compl_d = 1'b1;
                if (!m_wr_en_q) p1_rdata_d = m_rdata;
            end else begin
                p0_compl_d = 1'b1;
                if (!m_wr_en_q) p0_rdata_d = m_rdata;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wr_en_q   <= 1'b0;
            m_bytesel_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_compl_q  <= 1'b0;
            p1_compl_q  <= 1'b0;
            grant_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wr_en_q   <= m_wr_en_d;
            m_bytesel_q <= m_bytesel_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_compl_q  <= p0_compl_d;
            p1_compl_q  <= p1_compl_d;
            grant_q     <= grant_d;
        end
    end

    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wr_en   = m_wr_en_q;
    assign m_bytesel = m_bytesel_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_compl  = p0_compl_q;
    assign p1_compl  = p1_compl_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed phases plus randomized transactions against a port-level model.
// Latency: checks grant at the edge after an IDLE request and port compl one edge after m_compl.
// Backpressure: requesters hold requests until compl; a second instance exercises fixed priority.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] p0_addr, p1_addr, m_addr;
    logic [15:0] p0_wdata, p1_wdata, m_wdata;
    logic        p0_wr_en, p1_wr_en, m_wr_en;
    logic [1:0]  p0_bytesel, p1_bytesel, m_bytesel;
    logic [15:0] p0_rdata, p1_rdata, m_rdata;
    logic        p0_compl, p1_compl, m_compl, m_config_done, grant;

    // Fixed-priority instance signals
    logic        fp_req;
    logic [31:0] fp_m_addr;
    logic [15:0] fp_m_wdata, fp_m_rdata, fp_p0_rdata, fp_p1_rdata;
    logic        fp_m_wr_en, fp_m_compl, fp_p0_compl, fp_p1_compl, fp_grant;
    logic [1:0]  fp_m_bytesel, fp_bs;

    int checks   = 0;
    int failures = 0;

    // Port-level model state
    bit          pend      [2];
    logic [31:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        req_wr    [2];
    logic [1:0]  req_bs    [2];
    logic [15:0] exp_rdata [2];
    int          last_g;

    always #5 clk = ~clk;

    assign fp_bs = fp_req ? 2'b11 : 2'b00;

    sdram_arbiter #(.FIXED_PRIO(0), .RESET_HOLDOFF(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wr_en(p0_wr_en), .p0_bytesel(p0_bytesel),
        .p0_rdata(p0_rdata), .p0_compl(p0_compl),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wr_en(p1_wr_en), .p1_bytesel(p1_bytesel),
        .p1_rdata(p1_rdata), .p1_compl(p1_compl),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
        .m_rdata(m_rdata), .m_compl(m_compl), .m_config_done(m_config_done), .grant(grant)
    );

    sdram_arbiter #(.FIXED_PRIO(1), .RESET_HOLDOFF(16)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(32'h0000_00A0), .p0_wdata(16'h1111), .p0_wr_en(1'b0), .p0_bytesel(fp_bs),
        .p0_rdata(fp_p0_rdata), .p0_compl(fp_p0_compl),
        .p1_addr(32'h0000_00B0), .p1_wdata(16'h2222), .p1_wr_en(1'b0), .p1_bytesel(fp_bs),
        .p1_rdata(fp_p1_rdata), .p1_compl(fp_p1_compl),
        .m_addr(fp_m_addr), .m_wdata(fp_m_wdata), .m_wr_en(fp_m_wr_en), .m_bytesel(fp_m_bytesel),
        .m_rdata(fp_m_rdata), .m_compl(fp_m_compl), .m_config_done(m_config_done), .grant(fp_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ports();
        p0_addr    = req_addr[0];
        p0_wdata   = req_wdata[0];
        p0_wr_en   = req_wr[0];
        p0_bytesel = pend[0] ? req_bs[0] : 2'b00;
        p1_addr    = req_addr[1];
        p1_wdata   = req_wdata[1];
        p1_wr_en   = req_wr[1];
        p1_bytesel = pend[1] ? req_bs[1] : 2'b00;
    endtask

    task automatic new_req(input int p);
        pend[p]      = 1'b1;
        req_addr[p]  = $urandom;
        req_wdata[p] = 16'($urandom);
        req_wr[p]    = 1'($urandom_range(0, 1));
        req_bs[p]    = 2'($urandom_range(1, 3));
    endtask

    // Called in an IDLE cycle with at least one request pending; runs one full transaction.
    task automatic do_txn(input int lat, input logic [15:0] rd, output int won);
        int w;
        drive_ports();
        if (pend[0] && pend[1]) w = 1 - last_g;
        else                    w = pend[0] ? 0 : 1;
        won = w;
        tick();
        chk("grant_idx", 32'(grant), 32'(w));
        chk("grant_addr", m_addr, req_addr[w]);
        chk("grant_wdata", 32'(m_wdata), 32'(req_wdata[w]));
        chk("grant_wr", 32'(m_wr_en), 32'(req_wr[w]));
        chk("grant_bs", 32'(m_bytesel), 32'(req_bs[w]));
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("hold_bs", 32'(m_bytesel), 32'(req_bs[w]));
            chk("hold_addr", m_addr, req_addr[w]);
            chk("busy_no_compl", 32'({p1_compl, p0_compl}), 32'(0));
        end
        m_compl = 1'b1;
        m_rdata = rd;
        tick();
        m_compl = 1'b0;
        m_rdata = 16'($urandom);
        if (!req_wr[w]) exp_rdata[w] = rd;
        chk("compl_pulse", 32'({p1_compl, p0_compl}), (w == 1) ? 32'd2 : 32'd1);
        chk("bs_cleared", 32'(m_bytesel), 32'(0));
        chk("p0_rdata", 32'(p0_rdata), 32'(exp_rdata[0]));
        chk("p1_rdata", 32'(p1_rdata), 32'(exp_rdata[1]));
        pend[w] = 1'b0;
        drive_ports();
        last_g = w;
        tick();
        chk("release_no_grant", 32'(m_bytesel), 32'(0));
        chk("compl_one_cycle", 32'({p1_compl, p0_compl}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int won, grants, busy;
        logic [15:0] fp_rd;

        // ---- Reset state ----
        rst_n = 1'b0; m_compl = 1'b0; m_rdata = '0; m_config_done = 1'b0;
        fp_req = 1'b0; fp_m_compl = 1'b0; fp_m_rdata = '0; fp_rd = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; req_addr[p] = '0; req_wdata[p] = '0;
            req_wr[p] = 1'b0; req_bs[p] = 2'b00; exp_rdata[p] = '0;
        end
        last_g = 1;  // reset favours port 0
        drive_ports();
        tick(); tick(); tick();
        chk("rst_bs", 32'(m_bytesel), 32'(0));
        chk("rst_addr", m_addr, 32'(0));
        chk("rst_wdata", 32'(m_wdata), 32'(0));
        chk("rst_wr", 32'(m_wr_en), 32'(0));
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_compl", 32'({p1_compl, p0_compl}), 32'(0));
        chk("rst_rdata", 32'({p1_rdata, p0_rdata}), 32'(0));

        // ---- Holdoff / config wait with pending p0 read and MRS completion ----
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            chk("holdoff_bs", 32'(m_bytesel), 32'(0));
            chk("holdoff_no_compl", 32'(p0_compl), 32'(0));
            m_compl = (c == 38);
            if (c == 5) begin
                pend[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 16'h0;
                req_wr[0] = 1'b0; req_bs[0] = 2'b11;
                drive_ports();
            end
            if (c == 40) m_config_done = 1'b1;
        end
        tick();
        chk("wait_cfg_exit", 32'(m_bytesel), 32'(0));
        do_txn(3, 16'h5A5A, won);

        // ---- Single p0 write: rdata must stay put ----
        pend[0] = 1'b1; req_addr[0] = 32'h0000_0100; req_wdata[0] = 16'hBEEF;
        req_wr[0] = 1'b1; req_bs[0] = 2'b11;
        do_txn(4, 16'hDEAD, won);

        // ---- Single p1 read ----
        pend[1] = 1'b1; req_addr[1] = 32'h0000_2000; req_wdata[1] = 16'h0;
        req_wr[1] = 1'b0; req_bs[1] = 2'b10;
        do_txn(2, 16'h1234, won);
        chk("p1_read_data", 32'(p1_rdata), 32'h1234);

        // ---- Both ports requesting: round-robin alternation ----
        for (int k = 0; k < 4; k++) begin
            if (!pend[0]) new_req(0);
            if (!pend[1]) new_req(1);
            do_txn(int'($urandom_range(1, 3)), 16'($urandom), won);
            chk("rr_sequence", 32'(won), 32'(k % 2));
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_ports();

        // ---- Fixed-priority instance: both request continuously ----
        fp_req = 1'b1; grants = 0; busy = 0;
        for (int c = 0; c < 200 && grants < 4; c++) begin
            tick();
            chk("fp_p1_never", 32'(fp_p1_compl), 32'(0));
            if (fp_m_compl) begin
                chk("fp_p0_compl", 32'(fp_p0_compl), 32'(1));
                chk("fp_p0_rdata", 32'(fp_p0_rdata), 32'(fp_rd));
                fp_m_compl = 1'b0;
                busy = 0;
            end else if (fp_m_bytesel != 2'b00) begin
                if (busy == 0) begin
                    grants++;
                    chk("fp_grant", 32'(fp_grant), 32'(0));
                    chk("fp_addr", fp_m_addr, 32'h0000_00A0);
                    chk("fp_wdata", 32'(fp_m_wdata), 32'h1111);
                    chk("fp_wr", 32'(fp_m_wr_en), 32'(0));
                end
                busy++;
                if (busy == 2) begin
                    fp_rd = 16'($urandom);
                    fp_m_rdata = fp_rd;
                    fp_m_compl = 1'b1;
                end
            end
        end
        chk("fp_grant_count", 32'(grants), 32'(4));
        chk("fp_p1_rdata", 32'(fp_p1_rdata), 32'(0));
        fp_req = 1'b0; fp_m_compl = 1'b0;

        // ---- Reset in the middle of BUSY ----
        pend[0] = 1'b1; req_addr[0] = 32'h300; req_wdata[0] = 16'h0;
        req_wr[0] = 1'b0; req_bs[0] = 2'b01;
        drive_ports();
        tick();
        chk("pre_rst_bs", 32'(m_bytesel), 32'(1));
        tick();
        rst_n = 1'b0;
        #1;
        last_g = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
        chk("midrst_bs", 32'(m_bytesel), 32'(0));
        chk("midrst_addr", m_addr, 32'(0));
        chk("midrst_grant", 32'(grant), 32'(0));
        chk("midrst_rdata", 32'({p1_rdata, p0_rdata}), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("rst_holdoff_bs", 32'(m_bytesel), 32'(0));
            chk("stray_compl", 32'({p1_compl, p0_compl}), 32'(0));
            m_compl = (i == 5);
            m_rdata = (i == 5) ? 16'hFFFF : 16'h0000;
        end
        do_txn(2, 16'h0BAD, won);

        // ---- Randomized traffic ----
        for (int t = 0; t < 30; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) new_req(p);
            end
            if (!pend[0] && !pend[1]) begin
                tick();
                chk("idle_no_grant", 32'(m_bytesel), 32'(0));
                new_req(int'($urandom_range(0, 1)));
            end
            do_txn(int'($urandom_range(1, 5)), 16'($urandom), won);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
